down_timer: RTL and testbench

DOWN_TIMER -- requirements
Module: down_timer

---
 rtl/down_timer.sv | 108 ++++++++++
 tb/tb_down_timer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/down_timer.sv
// down_timer: loadable N-bit down counter with one-shot and periodic modes.
// Latency: start -> busy/count visible 1 cycle later; terminal tick -> done 1 cycle later.
// Backpressure: none; en gates counting, stop aborts, start (re)loads at any time.
//
// Ports:
//   clk     - clock, rising-edge
//   rst     - asynchronous active-high reset
//   start   - load ld_val into count/reload, latch mode, enter RUN
//   stop    - abort to IDLE, count held, no done (overrides everything)
//   mode    - 0 = one-shot, 1 = periodic; sampled only on an accepted start
//   en      - count-tick enable (ignored in IDLE)
//   ld_val  - initial and reload value
//   count   - current counter value (registered)
//   busy    - high while in RUN (registered)
//   done    - one-cycle pulse after a terminal tick (registered)
//   zero    - combinational count == 0
module down_timer #(
  parameter int N = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stop,
  input  logic         mode,
  input  logic         en,
  input  logic [N-1:0] ld_val,
  output logic [N-1:0] count,
  output logic         busy,
  output logic         done,
  output logic         zero
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  state_t       r_state;
  state_t       w_state_nxt;
  logic [N-1:0] r_count;
  logic [N-1:0] w_count_nxt;
  logic [N-1:0] r_reload;
  logic [N-1:0] w_reload_nxt;
  logic         r_mode;
  logic         w_mode_nxt;
  logic         r_done;
  logic         w_done_nxt;
  logic         w_tick;
  logic         w_terminal;

  // A tick only counts when neither start nor stop claims the cycle.
  assign w_tick     = (r_state == S_RUN) && en && !start && !stop;
  // count <= 1 (not == 1) so a zero load terminates on its first tick
  // instead of wrapping to all-ones.
  assign w_terminal = w_tick && (r_count <= ONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_reload <= '0;
      r_mode   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_reload <= w_reload_nxt;
      r_mode   <= w_mode_nxt;
      r_done   <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_reload_nxt = r_reload;
    w_mode_nxt   = r_mode;
    w_done_nxt   = 1'b0;

    // Priority: stop > start > terminal > plain tick.
    if (stop) begin
      w_state_nxt = S_IDLE;
    end else if (start) begin
      w_state_nxt  = S_RUN;
      w_count_nxt  = ld_val;
      w_reload_nxt = ld_val;
      w_mode_nxt   = mode;
    end else if (w_terminal) begin
      w_done_nxt = 1'b1;
      if (r_mode) begin
        w_count_nxt = r_reload;
      end else begin
        w_count_nxt = '0;
        w_state_nxt = S_IDLE;
      end
    end else if (w_tick) begin
      w_count_nxt = r_count - ONE;
    end
  end

  assign count = r_count;
  assign busy  = (r_state == S_RUN);
  assign done  = r_done;
  assign zero  = (r_count == '0);

endmodule

// File: tb/tb_down_timer.sv
// tb_down_timer: directed stimulus with a queued expectation per cycle.
// Latency: one expectation per clock, compared 1 time unit after the edge.
// Backpressure: n/a.
module tb_down_timer;

  localparam int N = 6;

  logic         clk;
  logic         rst;
  logic         start;
  logic         stop;
  logic         mode;
  logic         en;
  logic [N-1:0] ld_val;
  logic [N-1:0] count;
  logic         busy;
  logic         done;
  logic         zero;

  down_timer #(.N(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .stop   (stop),
    .mode   (mode),
    .en     (en),
    .ld_val (ld_val),
    .count  (count),
    .busy   (busy),
    .done   (done),
    .zero   (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] cnt;
    logic         bsy;
    logic         dn;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: tracks ticks remaining until the terminal tick of the
  // current period, and derives the visible count from that.
  int           m_left;
  logic [N-1:0] m_count;
  logic [N-1:0] m_reload;
  logic         m_mode;
  logic         m_busy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic model_reset();
    m_left   = 0;
    m_count  = '0;
    m_reload = '0;
    m_mode   = 1'b0;
    m_busy   = 1'b0;
  endtask

  task automatic compare_front(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      $error("FAIL %s: observed empty scoreboard expected one entry", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, ".count"}, 32'(count), 32'(e.cnt));
      check({tag, ".busy"},  32'(busy),  32'(e.bsy));
      check({tag, ".done"},  32'(done),  32'(e.dn));
      check({tag, ".zero"},  32'(zero),  32'(e.cnt == '0));
    end
  endtask

  // Drive one cycle of inputs, push the model's expectation, clock, compare.
  task automatic step(input string tag, input logic s, input logic p,
                      input logic md, input logic e, input logic [N-1:0] ld);
    exp_t x;
    logic exp_done;
    start  = s;
    stop   = p;
    mode   = md;
    en     = e;
    ld_val = ld;
    exp_done = 1'b0;
    if (p) begin
      m_busy = 1'b0;
    end else if (s) begin
      m_busy   = 1'b1;
      m_reload = ld;
      m_mode   = md;
      m_count  = ld;
      m_left   = (ld == '0) ? 1 : int'(ld);
    end else if (m_busy && e) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        exp_done = 1'b1;
        if (m_mode) begin
          m_left  = (m_reload == '0) ? 1 : int'(m_reload);
          m_count = m_reload;
        end else begin
          m_count = '0;
          m_busy  = 1'b0;
        end
      end else begin
        m_count = N'(m_left);
      end
    end
    x.cnt = m_count;
    x.bsy = m_busy;
    x.dn  = exp_done;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    compare_front(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    stop   = 1'b0;
    mode   = 1'b0;
    en     = 1'b0;
    ld_val = '0;
    model_reset();

    // Reset state, before any clock edge.
    #2;
    check("rst.count", 32'(count), 32'd0);
    check("rst.busy",  32'(busy),  32'd0);
    check("rst.done",  32'(done),  32'd0);
    check("rst.zero",  32'(zero),  32'd1);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Idle ignores en.
    step("idle_en", 0, 0, 0, 1, 6'd0);

    // One-shot ld=5: 5,4,3,2,1,0(done), then stays 0.
    step("os_start", 1, 0, 0, 1, 6'd5);
    check("os_first", 32'(count), 32'd5);
    for (int i = 0; i < 6; i++) step("os_tick", 0, 0, 0, 1, 6'd0);

    // Periodic ld=3 with en toggling.
    step("per_start", 1, 0, 1, 0, 6'd3);
    for (int i = 0; i < 14; i++) step("per_tick", 0, 0, 0, (i % 2) == 0, 6'd0);
    check("per_busy", 32'(busy), 32'd1);

    // Stop at count=6 from ld=10.
    step("stop_start", 1, 0, 0, 1, 6'd10);
    for (int i = 0; i < 4; i++) step("stop_tick", 0, 0, 0, 1, 6'd0);
    step("stop", 0, 1, 0, 1, 6'd0);
    check("stop_hold", 32'(count), 32'd6);
    step("stop_idle1", 0, 0, 0, 1, 6'd0);
    step("stop_idle2", 0, 0, 0, 1, 6'd0);
    check("stop_after_en", 32'(count), 32'd6);

    // Start in the terminal cycle wins.
    step("col_a_start", 1, 0, 0, 1, 6'd2);
    step("col_a_tick", 0, 0, 0, 1, 6'd0);
    step("col_a_restart", 1, 0, 0, 1, 6'd4);
    check("col_a_cnt", 32'(count), 32'd4);
    // Stop in the terminal cycle wins.
    for (int i = 0; i < 3; i++) step("col_b_tick", 0, 0, 0, 1, 6'd0);
    step("col_b_stop", 0, 1, 0, 1, 6'd0);
    check("col_b_cnt", 32'(count), 32'd1);
    // Start and stop together: stop wins, count held.
    step("col_c_start", 1, 0, 0, 1, 6'd5);
    step("col_c_tick", 0, 0, 0, 1, 6'd0);
    step("col_c_both", 1, 1, 1, 1, 6'd9);
    check("col_c_cnt", 32'(count), 32'd4);
    step("col_c_idle", 0, 0, 0, 1, 6'd0);

    // Async reset mid-run at count=7.
    step("ar_start", 1, 0, 1, 1, 6'd9);
    step("ar_tick1", 0, 0, 0, 1, 6'd0);
    step("ar_tick2", 0, 0, 0, 1, 6'd0);
    check("ar_pre", 32'(count), 32'd7);
    #2 rst = 1'b1;
    #1;
    model_reset();
    exp_q.push_back('{cnt: '0, bsy: 1'b0, dn: 1'b0});
    compare_front("ar_async");
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) step("ar_idle", 0, 0, 0, 1, 6'd0);

    // Zero loads.
    step("z_os_start", 1, 0, 0, 0, 6'd0);
    step("z_os_wait", 0, 0, 0, 0, 6'd0);
    step("z_os_tick", 0, 0, 0, 1, 6'd0);
    check("z_os_done", 32'(done), 32'd1);
    step("z_os_after", 0, 0, 0, 1, 6'd0);
    step("z_per_start", 1, 0, 1, 1, 6'd0);
    step("z_per_t1", 0, 0, 0, 1, 6'd0);
    step("z_per_t2", 0, 0, 0, 1, 6'd0);
    step("z_per_gap", 0, 0, 0, 0, 6'd0);
    step("z_per_t3", 0, 0, 0, 1, 6'd0);
    check("z_per_done", 32'(done), 32'd1);

    // Periodic reload=1: done every enabled tick, then a coinciding stop.
    step("r1_start", 1, 0, 1, 1, 6'd1);
    step("r1_t1", 0, 0, 0, 1, 6'd0);
    step("r1_t2", 0, 0, 0, 1, 6'd0);
    step("r1_stop", 0, 1, 0, 1, 6'd0);
    step("r1_idle", 0, 0, 0, 1, 6'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
